// File: rtl/to8bit_pkg.sv
// Shared definitions for the 8/16/32-bit to byte-stream serializer.
package to8bit_pkg;

    // Data widths: output byte, half-word input, word input and word residue buffer.
    localparam int BYTE_W  = 8;
    localparam int HALF_W  = 16;
    localparam int WORD_W  = 32;
    localparam int BUF32_W = 24;

    // Mode select encodings for dataS.
    localparam logic [1:0] MODE_8    = 2'b00;
    localparam logic [1:0] MODE_16   = 2'b01;
    localparam logic [1:0] MODE_32   = 2'b10;
    localparam logic [1:0] MODE_IDLE = 2'b11;

    // Byte phase within a 32-bit word; PH_0 is the word-load boundary.
    typedef enum logic [1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2,
        PH_3 = 2'd3
    } phase_e;

    // Successor of a phase value, wrapping PH_3 back to PH_0.
    function automatic phase_e next_phase(input phase_e ph);
        phase_e nxt;
        case (ph)
            PH_0:    nxt = PH_1;
            PH_1:    nxt = PH_2;
            PH_2:    nxt = PH_3;
            default: nxt = PH_0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/to_8bit_phase_gen.sv
// Free-running 2-bit byte-phase counter with half-word and word load strobes.
// The phase advances on every enabled edge regardless of mode, so all modes
// share one byte timeline and a mode change never realigns it.
module to_8bit_phase_gen
    import to8bit_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,   // synchronous, active-low
    input  logic       i_enb,
    output logic [1:0] o_phase,
    output logic       o_ld16,
    output logic       o_ld32
);

    phase_e r_phase;
    phase_e w_phase_nxt;

    // Phase register: cleared by reset, otherwise takes the computed next phase.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_phase <= PH_0;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Next phase: hold while disabled, otherwise step and wrap.
    always_comb begin
        w_phase_nxt = r_phase;
        if (i_enb) begin
            w_phase_nxt = next_phase(r_phase);
        end
    end

    // Half-words load on even phases, words only at the boundary.
    assign o_phase = r_phase;
    assign o_ld16  = ~r_phase[0];
    assign o_ld32  = (r_phase == PH_0);

endmodule

// File: rtl/to_8bit_serializer.sv
// Width adapter: serialises 8-, 16- or 32-bit words MSB byte first onto one
// registered byte stream, paced by a shared byte-phase counter.
module to_8bit_serializer
    import to8bit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,        // synchronous, active-low; overrides enb
    input  logic              enb,        // 0 freezes all state cycle-exactly
    input  logic [BYTE_W-1:0] dataIn,
    input  logic [HALF_W-1:0] dataIn16,
    input  logic [WORD_W-1:0] dataIn32,
    input  logic [1:0]        dataS,
    output logic [BYTE_W-1:0] dataOut,
    output logic [1:0]        o_dbg_phase // current byte phase, for observation
);

    logic [1:0]         w_phase;
    logic               w_ld16;
    logic               w_ld32;

    logic [BYTE_W-1:0]  r_data_out;
    logic [BYTE_W-1:0]  r_buf16;
    logic [BUF32_W-1:0] r_buf32;

    logic [BYTE_W-1:0]  w_data_out_nxt;
    logic [BYTE_W-1:0]  w_buf16_nxt;
    logic [BUF32_W-1:0] w_buf32_nxt;

    to_8bit_phase_gen u_phase_gen (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_enb   (enb),
        .o_phase (w_phase),
        .o_ld16  (w_ld16),
        .o_ld32  (w_ld32)
    );

    // Datapath next state: the phase seen here is the value before this edge's increment.
    // Entering 01/10 mid-word deliberately replays whatever is left in the buffers.
    always_comb begin
        w_data_out_nxt = r_data_out;
        w_buf16_nxt    = r_buf16;
        w_buf32_nxt    = r_buf32;
        if (enb) begin
            case (dataS)
                MODE_8: begin
                    w_data_out_nxt = dataIn;
                end
                MODE_16: begin
                    if (w_ld16) begin
                        w_data_out_nxt = dataIn16[HALF_W-1:BYTE_W];
                        w_buf16_nxt    = dataIn16[BYTE_W-1:0];
                    end else begin
                        w_data_out_nxt = r_buf16;
                    end
                end
                MODE_32: begin
                    if (w_ld32) begin
                        w_data_out_nxt = dataIn32[WORD_W-1:BUF32_W];
                        w_buf32_nxt    = dataIn32[BUF32_W-1:0];
                    end else begin
                        w_data_out_nxt = r_buf32[BUF32_W-1:BUF32_W-BYTE_W];
                        w_buf32_nxt    = {r_buf32[BUF32_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                    end
                end
                MODE_IDLE: begin
                    w_data_out_nxt = '0;
                end
                default: begin
                    w_data_out_nxt = '0;
                end
            endcase
        end
    end

    // Datapath registers: reset clears output and both buffers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data_out <= '0;
            r_buf16    <= '0;
            r_buf32    <= '0;
        end else begin
            r_data_out <= w_data_out_nxt;
            r_buf16    <= w_buf16_nxt;
            r_buf32    <= w_buf32_nxt;
        end
    end

    assign dataOut     = r_data_out;
    assign o_dbg_phase = w_phase;

endmodule

// File: tb/tb_to_8bit_serializer.sv
// Directed bench for to_8bit_serializer: expected bytes are queued when a word
// is driven and popped as each output byte appears.
module tb_to_8bit_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enb = 1'b0;
  logic [7:0]  dataIn = '0;
  logic [15:0] dataIn16 = '0;
  logic [31:0] dataIn32 = '0;
  logic [1:0]  dataS = 2'b11;
  logic [7:0]  dataOut;
  logic [1:0]  dbg_phase;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [1:0]  exp_phase = 2'd0;

  logic [7:0]  byte_vec[8];
  logic [15:0] half_vec[3];
  logic [31:0] word_vec[3];

  to_8bit_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .enb         (enb),
    .dataIn      (dataIn),
    .dataIn16    (dataIn16),
    .dataIn32    (dataIn32),
    .dataS       (dataS),
    .dataOut     (dataOut),
    .o_dbg_phase (dbg_phase)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) exp_phase = 2'd0;
    else if (enb) exp_phase = exp_phase + 2'd1;
    check("phase", {30'b0, dbg_phase}, {30'b0, exp_phase});
  endtask

  task automatic tick_pop(input string tag);
    logic [7:0] e;
    tick();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: observed=%0h expected=<empty queue>", tag, dataOut);
    end else begin
      e = exp_q.pop_front();
      check(tag, {24'b0, dataOut}, {24'b0, e});
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  initial begin
    byte_vec = '{8'hff, 8'hf0, 8'h0f, 8'h00, 8'h80, 8'h01, 8'ha6, 8'hd2};
    half_vec = '{16'had43, 16'h543f, 16'h7d5a};
    word_vec = '{32'h95fdad43, 32'h94d5543f, 32'h0378fdae};

    // reset held 4 clocks with random inputs
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dataIn   = 8'($urandom_range(0, 255));
      dataIn16 = 16'($urandom_range(0, 65535));
      dataIn32 = $urandom;
      dataS    = 2'($urandom_range(0, 3));
      enb      = 1'($urandom_range(0, 1));
      exp_q.push_back(8'h00);
      tick_pop("reset_out");
    end

    // release; idle mode, phase counts 0,1,2,3,0
    rst   = 1'b1;
    enb   = 1'b1;
    dataS = 2'b11;
    check("phase_after_reset", {30'b0, dbg_phase}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h00);
      tick_pop("idle_out");
    end

    // byte mode
    dataS = 2'b00;
    for (int i = 0; i < 8; i++) begin
      dataIn = byte_vec[i];
      exp_q.push_back(byte_vec[i]);
      tick_pop("byte");
    end

    // half-word mode, aligned at phase 0
    dataS = 2'b01;
    for (int i = 0; i < 3; i++) begin
      dataIn16 = half_vec[i];
      exp_q.push_back(half_vec[i][15:8]);
      exp_q.push_back(half_vec[i][7:0]);
      tick_pop("half_hi");
      tick_pop("half_lo");
    end

    // two idle bytes to realign to phase 0
    dataS = 2'b11;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'h00);
      tick_pop("idle_align");
    end

    // word mode, aligned
    dataS = 2'b10;
    for (int i = 0; i < 3; i++) begin
      dataIn32 = word_vec[i];
      push_word(word_vec[i]);
      for (int k = 0; k < 4; k++) tick_pop("word");
    end

    // enable freeze mid-word, inputs scrambled while frozen
    dataIn32 = 32'ha1b2c3d4;
    exp_q.push_back(8'ha1);
    exp_q.push_back(8'hb2);
    tick_pop("frz_pre");
    tick_pop("frz_pre");
    enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dataIn32 = $urandom;
      dataIn   = 8'($urandom_range(0, 255));
      exp_q.push_back(8'hb2);
      tick_pop("frz_hold");
    end
    enb = 1'b1;
    exp_q.push_back(8'hc3);
    exp_q.push_back(8'hd4);
    tick_pop("frz_resume");
    tick_pop("frz_resume");

    // 10 -> 01 switch at phase 2 loads the half-word high byte
    dataIn32 = 32'h11223344;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    tick_pop("mid_word");
    tick_pop("mid_word");
    dataS    = 2'b01;
    dataIn16 = 16'hbeef;
    exp_q.push_back(8'hbe);
    tick_pop("switch_16_hi");
    dataIn16 = 16'hffff;       // odd phase: must not be sampled
    exp_q.push_back(8'hef);
    tick_pop("switch_16_lo");

    // idle, then enter 01 at an odd phase: stale buf16 replays
    dataS = 2'b11;
    exp_q.push_back(8'h00);
    tick_pop("idle_mid");
    dataS = 2'b01;
    exp_q.push_back(8'hef);
    tick_pop("stale16");
    dataIn16 = 16'h1234;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    tick_pop("half_ld2");
    dataIn16 = 16'h0000;       // odd phase: must not be sampled
    tick_pop("half_ld2");

    // reset mid-word, with enb low to show reset wins
    dataS    = 2'b10;
    dataIn32 = 32'hcafebabe;
    exp_q.push_back(8'hca);
    exp_q.push_back(8'hfe);
    tick_pop("pre_rst");
    tick_pop("pre_rst");
    rst = 1'b0;
    enb = 1'b0;
    exp_q.push_back(8'h00);
    tick_pop("rst_mid");
    rst   = 1'b1;
    enb   = 1'b1;
    dataS = 2'b11;
    exp_q.push_back(8'h00);
    tick_pop("post_rst_idle");
    dataS = 2'b10;             // phase 1: drains the cleared word buffer
    exp_q.push_back(8'h00);
    tick_pop("rst_buf32");
    dataS    = 2'b01;
    dataIn16 = 16'h5678;
    exp_q.push_back(8'h56);
    exp_q.push_back(8'h78);
    tick_pop("post_rst_half");
    tick_pop("post_rst_half");
    dataS    = 2'b10;
    dataIn32 = 32'h0a0b0c0d;
    push_word(32'h0a0b0c0d);
    for (int k = 0; k < 4; k++) tick_pop("post_rst_word");

    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
